fetch_unit: RTL and testbench

Instruction-fetch stage of the RV32I/Zicsr 3-stage pipeline. It owns the program counter and runs a request/ready handshake to instruction memory, then presents fetched instructions to decode. It applies PC redirects from branches/jumps and from the CSR block: on illegal_inst or ecall the CSR block's r_data carries mtvec, and on mret it carries mepc. That r_data drives trap_target here. Redirect flushes the younger in-flight instruction and discards stale memory responses.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared types and constants for the instruction-fetch stage.
//   - fetch_state_e : 2-bit encodings of the fetch sequencer states
//   - INST_NOP      : canonical RV32I nop (addi x0, x0, 0)
//   - align_word()  : clears bits [1:0] of a redirect target (IALIGN = 32)
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_FETCH   = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Instruction-memory request/ready bus.
//   imem_req   : fetch request valid (driven by fetch)
//   imem_addr  : word-aligned fetch address (driven by fetch)
//   imem_ready : memory accepts the request; imem_rdata valid same cycle
//   imem_rdata : fetched instruction word
//   master = fetch stage side, slave = instruction memory side.
// ---------------------------------------------------------------------------
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage of the RV32I/Zicsr 3-stage pipeline. Owns the PC,
//   issues requests on the imem bus and presents fetched words to decode.
//   Branch/jump and trap/mret redirects flush the younger instruction and
//   discard any response belonging to the old path.
//
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   stall          : decode cannot accept an instruction this cycle
//   branch_taken   : execute resolved a taken branch/jal/jalr
//   branch_target  : destination for branch_taken
//   trap_redirect  : trap or mret seen by the CSR block this cycle
//   trap_target    : CSR r_data (mtvec or mepc)
//   imem           : instruction-memory bus (master side)
//   if_valid       : if_pc/if_inst hold a valid instruction for decode
//   if_pc, if_inst : PC and word of the presented instruction
//   flush          : combinational kill of decode/execute this cycle
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = INST_NOP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               trap_redirect,
  input  logic [31:0]        trap_target,
  fetch_unit_if.master       imem,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_inst,
  output logic               flush
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pending_pc_q, pending_pc_d;
  logic         req_hold_q, req_hold_d;
  logic         if_valid_d;
  logic [31:0]  if_pc_d, if_inst_d;

  logic         redirect;
  logic [31:0]  redirect_target;
  logic         fire;

  // Trap outranks branch when both arrive together.
  assign redirect        = trap_redirect | branch_taken;
  assign redirect_target = align_word(trap_redirect ? trap_target : branch_target);
  assign flush           = redirect;

  // A held request is never withdrawn, not even by a redirect: the memory
  // has already seen it and must be allowed to finish the transfer. In
  // DISCARD the pc still holds the old request address.
  always_comb begin
    imem.imem_req = 1'b0;
    case (state_q)
      FETCH_FETCH:   imem.imem_req = req_hold_q | (!redirect & (!if_valid | !stall));
      FETCH_DISCARD: imem.imem_req = 1'b1;
      default:       imem.imem_req = 1'b0;
    endcase
  end

  assign imem.imem_addr = pc_q;
  assign fire           = imem.imem_req & imem.imem_ready;

  // NOTE: every next-state variable is defaulted to its current value first,
  // so no path through the case statement can leave one unassigned (latch).
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    req_hold_d   = req_hold_q;
    if_valid_d   = if_valid;
    if_pc_d      = if_pc;
    if_inst_d    = if_inst;

    // Decode takes the instruction; a completion below may refill the slot.
    if (if_valid && !stall) begin
      if_valid_d = 1'b0;
      if_inst_d  = NOP_INST;
    end

    if (redirect) begin
      if_valid_d = 1'b0;
      if_inst_d  = NOP_INST;
    end

    case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_FETCH;
        if (redirect) pc_d = redirect_target;
      end

      FETCH_FETCH: begin
        if (redirect) begin
          req_hold_d = 1'b0;
          if (req_hold_q && !imem.imem_ready) begin
            // Old request still outstanding: park the target until it drains.
            state_d      = FETCH_DISCARD;
            pending_pc_d = redirect_target;
          end else begin
            pc_d = redirect_target;
          end
        end else if (fire) begin
          if_valid_d = 1'b1;
          if_inst_d  = imem.imem_rdata;
          if_pc_d    = pc_q;
          pc_d       = pc_q + 32'd4;
          req_hold_d = 1'b0;
        end else if (imem.imem_req) begin
          req_hold_d = 1'b1;
        end
      end

      FETCH_DISCARD: begin
        if (imem.imem_ready) begin
          // Stale response is dropped; resume on the newest target.
          state_d    = FETCH_FETCH;
          req_hold_d = 1'b0;
          pc_d       = redirect ? redirect_target : pending_pc_q;
        end else if (redirect) begin
          pending_pc_d = redirect_target;
        end
      end

      default: state_d = FETCH_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      pending_pc_q <= RESET_PC;
      req_hold_q   <= 1'b0;
      if_valid     <= 1'b0;
      if_pc        <= RESET_PC;
      if_inst      <= NOP_INST;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      req_hold_q   <= req_hold_d;
      if_valid     <= if_valid_d;
      if_pc        <= if_pc_d;
      if_inst      <= if_inst_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. The bench plays instruction memory
//   (word = hash of address). Directed scenarios check exact cycle timing;
//   a randomized run checks the delivered instruction stream against an
//   expected-PC model and the request/ready stability rule.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        trap_redirect = 1'b0;
  logic [31:0] trap_target = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        flush;

  int n_total = 0;
  int n_pass  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  fetch_unit_if imem();
  assign imem.imem_rdata = mem_word(imem.imem_addr);

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .trap_redirect (trap_redirect),
    .trap_target   (trap_target),
    .imem          (imem),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .flush         (flush)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge, apply ready/stall with no redirect,
  // then settle so outputs can be sampled mid-low-phase.
  task automatic next_cycle(input logic rdy, input logic stl);
    @(negedge clk);
    imem.imem_ready = rdy;
    stall           = stl;
    branch_taken    = 1'b0;
    trap_redirect   = 1'b0;
    #1;
  endtask

  // Reset, then release at a falling edge; leaves the bench in the first
  // post-release cycle with ready tied high and no stall.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem.imem_ready = 1'b1;
    stall = 1'b0; branch_taken = 1'b0; trap_redirect = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem.imem_ready = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; trap_redirect = 1'b0;
    #1;
    n_total++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid got=%0h exp=0", if_valid); else n_pass++;
    n_total++; if (if_pc !== 32'h0) $display("FAIL reset_if_pc got=%h exp=%h", if_pc, 32'h0); else n_pass++;
    n_total++; if (if_inst !== NOP) $display("FAIL reset_if_inst got=%h exp=%h", if_inst, NOP); else n_pass++;
    n_total++; if (imem.imem_req !== 1'b0) $display("FAIL reset_imem_req got=%0h exp=0", imem.imem_req); else n_pass++;
    n_total++; if (flush !== 1'b0) $display("FAIL reset_flush got=%0h exp=0", flush); else n_pass++;
  endtask

  task automatic test_sequential();
    do_reset();
    n_total++; if (imem.imem_req !== 1'b0) $display("FAIL seq_idle_req got=%0h exp=0", imem.imem_req); else n_pass++;
    next_cycle(1'b1, 1'b0);
    n_total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h0})
      $display("FAIL seq_first_req got=%0h/%h exp=1/%h", imem.imem_req, imem.imem_addr, 32'h0); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL seq_first_valid got=%0h exp=0", if_valid); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'(4 * k);
      next_cycle(1'b1, 1'b0);
      n_total++; if ({if_valid, if_pc, if_inst} !== {1'b1, exp_pc, mem_word(exp_pc)})
        $display("FAIL seq_stream got=%0h/%h/%h exp=1/%h/%h", if_valid, if_pc, if_inst, exp_pc, mem_word(exp_pc));
      else n_pass++;
    end
  endtask

  task automatic test_hold_stall();
    logic stall_pat [3];
    logic rdy_pat   [3];
    stall_pat = '{1'b1, 1'b0, 1'b1};
    rdy_pat   = '{1'b0, 1'b0, 1'b1};
    do_reset();
    next_cycle(1'b1, 1'b0);
    next_cycle(1'b1, 1'b0);
    next_cycle(1'b0, 1'b0);
    n_total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h8})
      $display("FAIL hold_issue got=%0h/%h exp=1/%h", imem.imem_req, imem.imem_addr, 32'h8); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      next_cycle(rdy_pat[i], stall_pat[i]);
      n_total++; if ({imem.imem_req, imem.imem_addr, if_valid} !== {1'b1, 32'h8, 1'b0})
        $display("FAIL hold_stable cyc=%0d got=%0h/%h/%0h exp=1/%h/0", i, imem.imem_req, imem.imem_addr, if_valid, 32'h8);
      else n_pass++;
    end
    next_cycle(1'b1, 1'b1);
    n_total++; if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h8, mem_word(32'h8)})
      $display("FAIL hold_deliver got=%0h/%h/%h exp=1/%h/%h", if_valid, if_pc, if_inst, 32'h8, mem_word(32'h8)); else n_pass++;
    n_total++; if (imem.imem_req !== 1'b0) $display("FAIL hold_stall_noreq got=%0h exp=0", imem.imem_req); else n_pass++;
    next_cycle(1'b1, 1'b0);
    n_total++; if ({if_valid, if_pc} !== {1'b1, 32'h8})
      $display("FAIL hold_stall_keep got=%0h/%h exp=1/%h", if_valid, if_pc, 32'h8); else n_pass++;
    next_cycle(1'b1, 1'b0);
    n_total++; if ({if_valid, if_pc} !== {1'b1, 32'hC})
      $display("FAIL hold_next got=%0h/%h exp=1/%h", if_valid, if_pc, 32'hC); else n_pass++;
  endtask

  task automatic test_branch_inflight();
    do_reset();
    repeat (4) next_cycle(1'b1, 1'b0);
    next_cycle(1'b0, 1'b0);
    n_total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h10})
      $display("FAIL br_setup got=%0h/%h exp=1/%h", imem.imem_req, imem.imem_addr, 32'h10); else n_pass++;
    next_cycle(1'b1, 1'b0);
    branch_taken = 1'b1; branch_target = 32'h100;
    #1;
    n_total++; if (flush !== 1'b1) $display("FAIL br_flush got=%0h exp=1", flush); else n_pass++;
    next_cycle(1'b1, 1'b0);
    n_total++; if ({flush, if_valid, if_inst} !== {1'b0, 1'b0, NOP})
      $display("FAIL br_dropped got=%0h/%0h/%h exp=0/0/%h", flush, if_valid, if_inst, NOP); else n_pass++;
    n_total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h100})
      $display("FAIL br_new_req got=%0h/%h exp=1/%h", imem.imem_req, imem.imem_addr, 32'h100); else n_pass++;
    next_cycle(1'b1, 1'b0);
    n_total++; if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h100, mem_word(32'h100)})
      $display("FAIL br_target got=%0h/%h/%h exp=1/%h/%h", if_valid, if_pc, if_inst, 32'h100, mem_word(32'h100)); else n_pass++;
  endtask

  task automatic test_trap_discard();
    do_reset();
    repeat (8) next_cycle(1'b1, 1'b0);
    next_cycle(1'b0, 1'b0);
    next_cycle(1'b0, 1'b0);
    trap_redirect = 1'b1; trap_target = 32'h0000_0203;
    #1;
    n_total++; if ({flush, imem.imem_req, imem.imem_addr} !== {1'b1, 1'b1, 32'h20})
      $display("FAIL trap_flush got=%0h/%0h/%h exp=1/1/%h", flush, imem.imem_req, imem.imem_addr, 32'h20); else n_pass++;
    next_cycle(1'b0, 1'b0);
    n_total++; if ({imem.imem_req, imem.imem_addr, if_valid} !== {1'b1, 32'h20, 1'b0})
      $display("FAIL trap_discard_hold got=%0h/%h/%0h exp=1/%h/0", imem.imem_req, imem.imem_addr, if_valid, 32'h20); else n_pass++;
    next_cycle(1'b1, 1'b0);
    next_cycle(1'b1, 1'b0);
    n_total++; if ({if_valid, imem.imem_req, imem.imem_addr} !== {1'b0, 1'b1, 32'h200})
      $display("FAIL trap_refetch got=%0h/%0h/%h exp=0/1/%h", if_valid, imem.imem_req, imem.imem_addr, 32'h200); else n_pass++;
    next_cycle(1'b1, 1'b0);
    n_total++; if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h200, mem_word(32'h200)})
      $display("FAIL trap_target got=%0h/%h/%h exp=1/%h/%h", if_valid, if_pc, if_inst, 32'h200, mem_word(32'h200)); else n_pass++;
  endtask

  task automatic test_simultaneous();
    next_cycle(1'b1, 1'b0);
    trap_redirect = 1'b1; trap_target = 32'h80;
    branch_taken = 1'b1; branch_target = 32'h40;
    #1;
    n_total++; if (flush !== 1'b1) $display("FAIL simul_flush got=%0h exp=1", flush); else n_pass++;
    next_cycle(1'b1, 1'b0);
    n_total++; if ({flush, if_valid, imem.imem_addr} !== {1'b0, 1'b0, 32'h80})
      $display("FAIL simul_single got=%0h/%0h/%h exp=0/0/%h", flush, if_valid, imem.imem_addr, 32'h80); else n_pass++;
    next_cycle(1'b1, 1'b0);
    n_total++; if ({if_valid, if_pc} !== {1'b1, 32'h80})
      $display("FAIL simul_target got=%0h/%h exp=1/%h", if_valid, if_pc, 32'h80); else n_pass++;
  endtask

  task automatic test_reset_mid_discard();
    do_reset();
    next_cycle(1'b1, 1'b0);
    next_cycle(1'b1, 1'b0);
    next_cycle(1'b0, 1'b0);
    next_cycle(1'b0, 1'b0);
    branch_taken = 1'b1; branch_target = 32'h300;
    #1;
    next_cycle(1'b0, 1'b0);
    n_total++; if ({imem.imem_req, imem.imem_addr, if_pc} !== {1'b1, 32'h8, 32'h4})
      $display("FAIL rst_setup got=%0h/%h/%h exp=1/%h/%h", imem.imem_req, imem.imem_addr, if_pc, 32'h8, 32'h4); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if ({if_valid, if_pc, if_inst, imem.imem_req} !== {1'b0, 32'h0, NOP, 1'b0})
      $display("FAIL rst_async got=%0h/%h/%h/%0h exp=0/%h/%h/0", if_valid, if_pc, if_inst, imem.imem_req, 32'h0, NOP);
    else n_pass++;
    imem.imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++; if (imem.imem_req !== 1'b0) $display("FAIL rst_idle_req got=%0h exp=0", imem.imem_req); else n_pass++;
    next_cycle(1'b1, 1'b0);
    n_total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h0})
      $display("FAIL rst_restart got=%0h/%h exp=1/%h", imem.imem_req, imem.imem_addr, 32'h0); else n_pass++;
    next_cycle(1'b1, 1'b0);
    n_total++; if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h0, mem_word(32'h0)})
      $display("FAIL rst_first_inst got=%0h/%h/%h exp=1/%h/%h", if_valid, if_pc, if_inst, 32'h0, mem_word(32'h0)); else n_pass++;
  endtask

  // Reference: decode must see the exact program-order stream starting at
  // RESET_PC, restarting at each aligned redirect target; a request left
  // unaccepted must be repeated unchanged next cycle.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic        prev_req, prev_ready;
    logic [31:0] prev_addr;
    logic        redir;
    int          consumed;
    exp_pc = 32'h0; prev_req = 1'b0; prev_ready = 1'b0; prev_addr = 32'h0; consumed = 0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      imem.imem_ready = ($urandom_range(0, 2) != 0);
      stall           = ($urandom_range(0, 3) == 0);
      branch_taken    = ($urandom_range(0, 11) == 0);
      trap_redirect   = ($urandom_range(0, 19) == 0);
      branch_target   = $urandom;
      trap_target     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      #1;
      redir = trap_redirect | branch_taken;
      n_total++; if (flush !== redir) $display("FAIL rnd_flush cyc=%0d got=%0h exp=%0h", cyc, flush, redir); else n_pass++;
      if (!if_valid) begin
        n_total++; if (if_inst !== NOP) $display("FAIL rnd_nop cyc=%0d got=%h exp=%h", cyc, if_inst, NOP); else n_pass++;
      end
      if (prev_req && !prev_ready) begin
        n_total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, prev_addr})
          $display("FAIL rnd_req_stable cyc=%0d got=%0h/%h exp=1/%h", cyc, imem.imem_req, imem.imem_addr, prev_addr);
        else n_pass++;
      end
      if (imem.imem_req) begin
        n_total++; if (imem.imem_addr[1:0] !== 2'b00)
          $display("FAIL rnd_align cyc=%0d got=%h exp=aligned", cyc, imem.imem_addr); else n_pass++;
      end
      if (redir) begin
        exp_pc = (trap_redirect ? trap_target : branch_target) & 32'hFFFF_FFFC;
      end else if (if_valid && !stall) begin
        n_total++; if ({if_pc, if_inst} !== {exp_pc, mem_word(exp_pc)})
          $display("FAIL rnd_stream cyc=%0d got=%h/%h exp=%h/%h", cyc, if_pc, if_inst, exp_pc, mem_word(exp_pc));
        else n_pass++;
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      prev_req   = imem.imem_req;
      prev_ready = imem.imem_ready;
      prev_addr  = imem.imem_addr;
    end
    n_total++; if (consumed < 30) $display("FAIL rnd_progress got=%0d exp>=30", consumed); else n_pass++;
  endtask

  initial begin
    imem.imem_ready = 1'b0;
    test_reset();
    test_sequential();
    test_hold_stall();
    test_branch_inflight();
    test_trap_discard();
    test_simultaneous();
    test_reset_mid_discard();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
